// File: rtl/xbar_rr_cmd_gen.sv
// Round-robin command generator feeding an 8:1 one-hot crossbar.
// Per-port single-entry buffers; one registered grant per cycle.
module xbar_rr_cmd_gen #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_INPUT_DATA = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_INPUT_DATA-1:0]            i_req_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_INPUT_DATA-1:0]            o_req_ready,
    input  logic                                 i_stall,
    output logic [NUM_INPUT_DATA-1:0]            o_valid,
    output logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    output logic                                 o_en,
    output logic [NUM_INPUT_DATA-1:0]            o_cmd
);

    localparam int unsigned N     = NUM_INPUT_DATA;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned PTR_W = $clog2(NUM_INPUT_DATA);

    logic [N-1:0]          buf_full_q, buf_full_d;
    logic [N-1:0][DW-1:0]  buf_data_q, buf_data_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;

    logic [N-1:0]          cmd_q, cmd_d;
    logic [N-1:0]          valid_q, valid_d;
    logic                  en_q, en_d;
    logic [N-1:0][DW-1:0]  data_bus_q, data_bus_d;

    logic [N-1:0]          grant_c;
    logic [PTR_W-1:0]      grant_idx_c;
    logic                  grant_any_c;
    logic [PTR_W-1:0]      scan_idx_c;
    logic [N-1:0]          accept_c;

    // Rotating priority scan starting at ptr; depends only on state and stall.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        scan_idx_c  = '0;
        if (!i_stall) begin
            for (int unsigned i = 0; i < N; i++) begin
                scan_idx_c = ptr_q + PTR_W'(i);
                if (!grant_any_c && buf_full_q[scan_idx_c]) begin
                    grant_c[scan_idx_c] = 1'b1;
                    grant_idx_c         = scan_idx_c;
                    grant_any_c         = 1'b1;
                end
            end
        end
    end

    // A granted buffer can be refilled on the same edge it drains.
    assign o_req_ready = {N{~rst}} & (~buf_full_q | grant_c);
    assign accept_c    = i_req_valid & o_req_ready;

    always_comb begin
        buf_full_d = (buf_full_q & ~grant_c) | accept_c;
        buf_data_d = buf_data_q;
        for (int unsigned p = 0; p < N; p++) begin
            if (accept_c[p]) begin
                buf_data_d[p] = i_req_data[p*DW +: DW];
            end
        end
        ptr_d = grant_any_c ? grant_idx_c + PTR_W'(1) : ptr_q;
    end

    always_comb begin
        cmd_d      = grant_c;
        valid_d    = grant_c;
        en_d       = grant_any_c;
        data_bus_d = '0;
        for (int unsigned p = 0; p < N; p++) begin
            if (grant_c[p]) begin
                data_bus_d[p] = buf_data_q[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full_q <= '0;
            buf_data_q <= '0;
            ptr_q      <= '0;
            cmd_q      <= '0;
            valid_q    <= '0;
            en_q       <= 1'b0;
            data_bus_q <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            ptr_q      <= ptr_d;
            cmd_q      <= cmd_d;
            valid_q    <= valid_d;
            en_q       <= en_d;
            data_bus_q <= data_bus_d;
        end
    end

    assign o_cmd      = cmd_q;
    assign o_valid    = valid_q;
    assign o_en       = en_q;
    assign o_data_bus = data_bus_q;

endmodule

// File: tb/tb_xbar_rr_cmd_gen.sv
// Directed bench for xbar_rr_cmd_gen: single port, full sweep, wrap,
// streaming, stall and mid-operation reset.
module tb_xbar_rr_cmd_gen;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned BW = N*DW;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [BW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          stall;
    logic [N-1:0]  valid;
    logic [BW-1:0] data_bus;
    logic          en;
    logic [N-1:0]  cmd;

    int errors = 0;
    int checks = 0;

    xbar_rr_cmd_gen #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .i_stall     (stall),
        .o_valid     (valid),
        .o_data_bus  (data_bus),
        .o_en        (en),
        .o_cmd       (cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] lane(input int p, input logic [DW-1:0] d);
        logic [BW-1:0] b;
        b = '0;
        b[p*DW +: DW] = d;
        return b;
    endfunction

    task automatic set_word(input int p, input logic [DW-1:0] d);
        req_data[p*DW +: DW] = d;
    endtask

    // Advance through one rising edge to the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        stall     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_en"},  BW'(en),    BW'(1'b0));
        check({tag, "_cmd"}, BW'(cmd),   BW'(8'h00));
        check({tag, "_vld"}, BW'(valid), BW'(8'h00));
        check({tag, "_bus"}, data_bus,   '0);
    endtask

    task automatic check_grant(input string tag, input int p, input logic [DW-1:0] d);
        logic [N-1:0] oh;
        oh = N'(1) << p;
        check({tag, "_en"},  BW'(en),    BW'(1'b1));
        check({tag, "_cmd"}, BW'(cmd),   BW'(oh));
        check({tag, "_vld"}, BW'(valid), BW'(oh));
        check({tag, "_bus"}, data_bus,   lane(p, d));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        stall     = 1'b0;
        #2;
        check_idle("reset");
        check("reset_rdy", BW'(req_ready), BW'(8'h00));
        @(negedge clk);
        rst = 1'b0;

        // Single word from port 3.
        req_valid[3] = 1'b1;
        set_word(3, 32'hA5A5_0003);
        #1;
        check("t1_rdy3", BW'(req_ready[3]), BW'(1'b1));
        tick();
        req_valid = '0;
        check_idle("t1_e1");
        tick();
        check_grant("t1_e2", 3, 32'hA5A5_0003);
        tick();
        check_idle("t1_e3");

        // All eight ports at once: grants 0..7 in order.
        do_reset();
        req_valid = 8'hFF;
        for (int p = 0; p < 8; p++) set_word(p, 32'h100 + 32'(p));
        tick();
        req_valid = '0;
        #1;
        check("t2_rdy_pre", BW'(req_ready), BW'(8'h01));
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] exp_rdy;
            tick();
            check_grant($sformatf("t2_g%0d", k), k, 32'h100 + 32'(k));
            exp_rdy = (k >= 6) ? 8'hFF : 8'((9'd1 << (k + 2)) - 9'd1);
            check($sformatf("t2_rdy%0d", k), BW'(req_ready), BW'(exp_rdy));
        end
        tick();
        check_idle("t2_end");

        // Pointer wrap: after port 6, ports 7 and 1 go 7 then 1.
        do_reset();
        req_valid[6] = 1'b1;
        set_word(6, 32'h6666_0006);
        tick();
        req_valid = '0;
        tick();
        check_grant("t3_g6", 6, 32'h6666_0006);
        req_valid = 8'b1000_0010;
        set_word(7, 32'h7777_0007);
        set_word(1, 32'h1111_0001);
        tick();
        req_valid = '0;
        check_idle("t3_gap");
        tick();
        check_grant("t3_g7", 7, 32'h7777_0007);
        tick();
        check_grant("t3_g1", 1, 32'h1111_0001);
        tick();
        check_idle("t3_end");

        // Continuous streaming from port 5.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c == 1 || c == 12) check($sformatf("t4_en_c%0d", c), BW'(en), BW'(1'b0));
            if (c >= 2 && c <= 11) check_grant($sformatf("t4_w%0d", c - 2), 5, 32'h500 + 32'(c - 2));
            if (c < 10) begin
                req_valid[5] = 1'b1;
                set_word(5, 32'h500 + 32'(c));
            end else begin
                req_valid[5] = 1'b0;
            end
            tick();
        end

        // Stall with ports 0 and 2 full.
        do_reset();
        stall     = 1'b1;
        req_valid = 8'b0000_0101;
        set_word(0, 32'hC0C0_0000);
        set_word(2, 32'hC2C2_0002);
        tick();
        req_valid = '0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check($sformatf("t5_rdy_s%0d", s), BW'(req_ready), BW'(8'b1111_1010));
            check($sformatf("t5_en_s%0d", s),  BW'(en),        BW'(1'b0));
            tick();
        end
        check_idle("t5_post");
        stall = 1'b0;
        #1;
        check("t5_rdy_rel", BW'(req_ready), BW'(8'b1111_1011));
        tick();
        check_grant("t5_g0", 0, 32'hC0C0_0000);
        tick();
        check_grant("t5_g2", 2, 32'hC2C2_0002);

        // Asynchronous reset with 4 buffers still full and o_en high.
        do_reset();
        req_valid = 8'b0001_1111;
        for (int p = 0; p < 5; p++) set_word(p, 32'hDEAD_0000 + 32'(p));
        tick();
        req_valid = '0;
        tick();
        check_grant("t6_pre", 0, 32'hDEAD_0000);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t6_async");
        check("t6_rdy_rst", BW'(req_ready), BW'(8'h00));
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_idle("t6_nostale1");
        req_valid[4] = 1'b1;
        set_word(4, 32'h4444_0004);
        tick();
        req_valid = '0;
        check_idle("t6_nostale2");
        tick();
        check_grant("t6_g4", 4, 32'h4444_0004);
        tick();
        check_idle("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
